// File: rtl/mux_pkg.sv
// Shared types and helpers for the arb_mux channel multiplexer.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Channel index width; never zero so single-channel builds stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request search: first asserted request after ptr, wrapping
// modulo Channels. Purely combinational.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int Channels = 4,
  localparam int IW       = idx_width(Channels)
) (
  input  logic [Channels-1:0] req,
  input  logic [IW-1:0]       ptr,
  output logic [Channels-1:0] grant,
  output logic [IW-1:0]       gnt_idx,
  output logic                any_gnt
);

  // Candidate k is the (k+1)-th channel after ptr; the last candidate is ptr itself.
  logic [IW-1:0] w_cand [Channels];

  for (genvar gi = 0; gi < Channels; gi++) begin : g_cand
    assign w_cand[gi] = IW'((int'(ptr) + gi + 1) % Channels);
  end

  always_comb begin
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < Channels; k++) begin
      if (!any_gnt && req[w_cand[k]]) begin
        any_gnt = 1'b1;
        gnt_idx = w_cand[k];
      end
    end
    grant = any_gnt ? (Channels'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel valid/ready multiplexer with fixed-select or round-robin grant
// and a single registered output stage.
module arb_mux
  import mux_pkg::*;
#(
  parameter  int Length   = 8,
  parameter  int Channels = 4,
  localparam int IW       = idx_width(Channels)
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [Channels*Length-1:0]   data_i,
  input  logic [Channels-1:0]          valid_i,
  output logic [Channels-1:0]          ready_o,
  input  logic                         mode_i,
  input  logic [IW-1:0]                sel_i,
  output logic [Length-1:0]            data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [IW-1:0]                chan_o
);

  logic [Length-1:0]   r_data;
  logic                r_valid;
  logic [IW-1:0]       r_chan;
  logic [IW-1:0]       r_ptr;

  mode_e               w_mode;
  logic                w_load_en;
  logic [Channels-1:0] w_fix_grant;
  logic                w_fix_any;
  logic [Channels-1:0] w_rr_grant;
  logic [IW-1:0]       w_rr_idx;
  logic                w_rr_any;
  logic [Channels-1:0] w_grant;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic [Length-1:0]   w_sel_data;

  assign w_mode    = mode_e'(mode_i);
  assign w_load_en = !r_valid || ready_i;

  // An out-of-range sel_i matches no channel, so it simply yields no grant.
  for (genvar gi = 0; gi < Channels; gi++) begin : g_fix
    assign w_fix_grant[gi] = valid_i[gi] && (sel_i == IW'(gi));
  end
  assign w_fix_any = |w_fix_grant;

  rr_arbiter #(
    .Channels (Channels)
  ) u_rr (
    .req     (valid_i),
    .ptr     (r_ptr),
    .grant   (w_rr_grant),
    .gnt_idx (w_rr_idx),
    .any_gnt (w_rr_any)
  );

  always_comb begin
    w_grant = w_fix_grant;
    w_idx   = sel_i;
    w_any   = w_fix_any;
    if (w_mode == MODE_RR) begin
      w_grant = w_rr_grant;
      w_idx   = w_rr_idx;
      w_any   = w_rr_any;
    end
  end

  // One-hot grant drives an AND-OR data select.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < Channels; k++) begin
      w_sel_data = w_sel_data | (data_i[k*Length +: Length] & {Length{w_grant[k]}});
    end
  end

  assign ready_o = (rstn_i && w_load_en) ? w_grant : '0;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= IW'(Channels - 1);
    end else if (w_load_en) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_sel_data;
        r_chan  <= w_idx;
        if (w_mode == MODE_RR) begin
          r_ptr <= w_idx;
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign chan_o  = r_chan;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux (Length=8, Channels=4): vector table,
// hand-written corner sequences and a randomised phase against a scoreboard.
module tb_arb_mux;

  logic        clk_i;
  logic        rstn_i;
  logic [31:0] data_i;
  logic [3:0]  valid_i;
  logic [3:0]  ready_o;
  logic        mode_i;
  logic [1:0]  sel_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic [1:0]  chan_o;

  arb_mux #(.Length(8), .Channels(4)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .mode_i  (mode_i),
    .sel_i   (sel_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .chan_o  (chan_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       m;
    logic [1:0] s;
    logic [3:0] v;
    logic       r;
    logic [31:0] d;
    logic [3:0] exp_rdy;
    logic       exp_vo;
    logic [7:0] exp_do;
    logic [1:0] exp_co;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] c;
  } word_t;

  int n_checks;
  int n_fail;

  logic       m_known;
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_chan;
  logic [1:0] m_ptr;
  word_t      sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: check combinational/held outputs, score any
  // output consume, step the model across the edge.
  task automatic cycle(input logic rst_n, input logic m, input logic [1:0] s,
                       input logic [3:0] v, input logic r, input logic [31:0] d,
                       output logic [3:0] rdy_seen);
    logic       load;
    logic       any;
    logic [1:0] g;
    logic [1:0] ci;
    logic [3:0] er;
    int         c;
    word_t      w;
    rstn_i = rst_n; mode_i = m; sel_i = s; valid_i = v; ready_i = r; data_i = d;
    #1;
    load = !m_valid || r;
    any  = 1'b0;
    g    = 2'd0;
    if (!m) begin
      if (v[s]) begin any = 1'b1; g = s; end
    end else begin
      for (int off = 1; off <= 4; off++) begin
        c  = (int'(m_ptr) + off) % 4;
        ci = 2'(c);
        if (!any && v[ci]) begin any = 1'b1; g = ci; end
      end
    end
    er = (rst_n && load && any) ? (4'b0001 << g) : 4'b0000;
    rdy_seen = ready_o;
    chk("ready_o", 32'(ready_o), 32'(er));
    if (m_known) begin
      chk("valid_o", 32'(valid_o), 32'(m_valid));
      chk("data_o", 32'(data_o), 32'(m_data));
      chk("chan_o", 32'(chan_o), 32'(m_chan));
      if (rst_n && m_valid && r) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          w = sb.pop_front();
          chk("sb_data", 32'(data_o), 32'(w.d));
          chk("sb_chan", 32'(chan_o), 32'(w.c));
          $display("tb: word out chan=%0d data=%02h", chan_o, data_o);
        end
      end
    end
    @(posedge clk_i);
    #1;
    if (!rst_n) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_chan  = 2'd0;
      m_ptr   = 2'd3;
      sb.delete();
    end else if (load) begin
      if (any) begin
        m_valid = 1'b1;
        m_data  = d[int'(g)*8 +: 8];
        m_chan  = g;
        if (m) m_ptr = g;
        w.d = m_data;
        w.c = g;
        sb.push_back(w);
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v,
                              input logic r, input logic [31:0] d, input logic [3:0] er,
                              input logic evo, input logic [7:0] edo, input logic [1:0] eco);
    vec_t t;
    t.m = m; t.s = s; t.v = v; t.r = r; t.d = d;
    t.exp_rdy = er; t.exp_vo = evo; t.exp_do = edo; t.exp_co = eco;
    return t;
  endfunction

  vec_t tbl[10];

  initial begin
    logic [3:0] rdy;
    n_checks = 0;
    n_fail   = 0;
    m_known  = 1'b0;
    m_valid  = 1'b0;
    m_data   = 8'h00;
    m_chan   = 2'd0;
    m_ptr    = 2'd3;
    rstn_i = 1'b0; mode_i = 1'b0; sel_i = 2'd0; valid_i = 4'hF; ready_i = 1'b1; data_i = 32'h0;

    // Fixed rows, then round-robin with ch2 idle: expect 0,1,3,0,1,3.
    tbl[0] = mk(1'b0, 2'd2, 4'b1111, 1'b1, 32'h44A52211, 4'b0100, 1'b1, 8'hA5, 2'd2);
    tbl[1] = mk(1'b0, 2'd2, 4'b1111, 1'b1, 32'h44A52211, 4'b0100, 1'b1, 8'hA5, 2'd2);
    tbl[2] = mk(1'b0, 2'd1, 4'b1101, 1'b1, 32'h44A52211, 4'b0000, 1'b0, 8'hA5, 2'd2);
    tbl[3] = mk(1'b0, 2'd3, 4'b1000, 1'b1, 32'h44A52211, 4'b1000, 1'b1, 8'h44, 2'd3);
    tbl[4] = mk(1'b1, 2'd0, 4'b1011, 1'b1, 32'hD4C3B2A1, 4'b0001, 1'b1, 8'hA1, 2'd0);
    tbl[5] = mk(1'b1, 2'd0, 4'b1011, 1'b1, 32'hD4C3B2A1, 4'b0010, 1'b1, 8'hB2, 2'd1);
    tbl[6] = mk(1'b1, 2'd0, 4'b1011, 1'b1, 32'hD4C3B2A1, 4'b1000, 1'b1, 8'hD4, 2'd3);
    tbl[7] = mk(1'b1, 2'd0, 4'b1011, 1'b1, 32'hD4C3B2A1, 4'b0001, 1'b1, 8'hA1, 2'd0);
    tbl[8] = mk(1'b1, 2'd0, 4'b1011, 1'b1, 32'hD4C3B2A1, 4'b0010, 1'b1, 8'hB2, 2'd1);
    tbl[9] = mk(1'b1, 2'd0, 4'b1011, 1'b1, 32'hD4C3B2A1, 4'b1000, 1'b1, 8'hD4, 2'd3);

    @(posedge clk_i);
    #1;

    // Reset held two cycles with every channel requesting.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 32'hFFFFFFFF, rdy);
      chk("rst_ready_o", 32'(rdy), 32'h0);
    end
    chk("rst_valid_o", 32'(valid_o), 32'h0);
    chk("rst_data_o", 32'(data_o), 32'h0);
    chk("rst_chan_o", 32'(chan_o), 32'h0);

    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].r, tbl[i].d, rdy);
      chk($sformatf("vec%0d_ready", i), 32'(rdy), 32'(tbl[i].exp_rdy));
      chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(tbl[i].exp_vo));
      chk($sformatf("vec%0d_data", i), 32'(data_o), 32'(tbl[i].exp_do));
      chk($sformatf("vec%0d_chan", i), 32'(chan_o), 32'(tbl[i].exp_co));
    end

    // Backpressure: word 3C must sit untouched for 5 stalled cycles.
    cycle(1'b1, 1'b0, 2'd1, 4'b0010, 1'b1, 32'h00003C00, rdy);
    chk("bp_load_data", 32'(data_o), 32'h3C);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 2'd1, 4'b1111, 1'b0, $urandom, rdy);
      chk("bp_ready_o", 32'(rdy), 32'h0);
      chk("bp_hold_data", 32'(data_o), 32'h3C);
      chk("bp_hold_valid", 32'(valid_o), 32'h1);
    end
    cycle(1'b1, 1'b0, 2'd1, 4'b0010, 1'b1, 32'h00005A00, rdy);
    chk("bp_release_ready", 32'(rdy), 32'b0010);
    chk("bp_release_data", 32'(data_o), 32'h5A);
    chk("bp_release_valid", 32'(valid_o), 32'h1);

    // Empty inputs: valid drops, data holds.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 2'd1, 4'b0000, 1'b1, 32'h12345678, rdy);
      chk("empty_valid", 32'(valid_o), 32'h0);
      chk("empty_data_hold", 32'(data_o), 32'h5A);
    end

    // Mid-operation reset with a stalled word; RR restarts at channel 0.
    cycle(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 32'h44332211, rdy);
    cycle(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 32'h44332211, rdy);
    chk("mr_pre_chan", 32'(chan_o), 32'h1);
    cycle(1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 32'h44332211, rdy);
    chk("mr_stall_valid", 32'(valid_o), 32'h1);
    cycle(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 32'h44332211, rdy);
    chk("mr_rst_ready", 32'(rdy), 32'h0);
    chk("mr_rst_valid", 32'(valid_o), 32'h0);
    cycle(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 32'h44332211, rdy);
    chk("mr_restart_ready", 32'(rdy), 32'b0001);
    chk("mr_restart_chan", 32'(chan_o), 32'h0);
    chk("mr_restart_data", 32'(data_o), 32'h11);

    // Randomised traffic against the model and scoreboard.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) != 0), 1'($urandom), 2'($urandom), 4'($urandom),
            ($urandom_range(0, 3) != 0), $urandom, rdy);
      chk("rand_onehot", 32'($countones(rdy) <= 1), 32'h1);
    end
    cycle(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 32'h0, rdy);
    chk("sb_drain", 32'(sb.size()), 32'(m_valid));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter Length, default 8: data width in bits per channel; Length >= 1.
REQ-002 Parameter Channels, default 4: number of input channels; Channels >= 2.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rstn_i  input  1  reset, synchronous, active-low.
REQ-005 data_i  input  Channels*Length  packed channel data; channel k occupies bits [k*Length +: Length].
REQ-006 valid_i  input  Channels  per-channel valid.
REQ-007 ready_o  output  Channels  per-channel ready; a channel transfers when valid_i[k] and ready_o[k] are both high at a clock edge.
REQ-008 mode_i  input  1  0 = fixed select, 1 = round-robin.
REQ-009 sel_i  input  $clog2(Channels)  channel index used in fixed mode.
REQ-010 data_o  output  Length  registered output data.
REQ-011 valid_o  output  1  registered output valid.
REQ-012 ready_i  input  1  downstream ready; output transfers when valid_o and ready_i are both high.
REQ-013 chan_o  output  $clog2(Channels)  index of the channel that supplied the current data_o.

Function
REQ-014 The block SHALL hold one output register stage (data_o, valid_o, chan_o); input-to-output latency is exactly 1 cycle.
REQ-015 load_en SHALL equal (!valid_o | ready_i); the register accepts new data only when load_en is high.
REQ-016 At most one ready_o bit SHALL be high per cycle, and only for the granted channel, and only when load_en is high.
REQ-017 Fixed mode: grant goes to channel sel_i when valid_i[sel_i] is high; if sel_i >= Channels, no grant.
REQ-018 Round-robin mode: grant goes to the first channel with valid_i set, searching ptr+1, ptr+2, ... mod Channels, where ptr is the last granted channel.
REQ-019 ptr SHALL update to the granted index only on an accepted transfer; it is unchanged in fixed mode.
REQ-020 On transfer: data_o <= selected channel data, chan_o <= granted index, valid_o <= 1.
REQ-021 If load_en is high and there is no grant: valid_o <= 0; data_o and chan_o hold their values.
REQ-022 If valid_o high and ready_i low: data_o, chan_o, and valid_o hold; all ready_o are 0.
REQ-023 Simultaneous output consume and input accept in the same cycle SHALL sustain one transfer per cycle with no bubble.
REQ-024 Changes to mode_i or sel_i take effect on the grant decision of the same cycle; an in-flight output word is never altered.
REQ-025 ready_o SHALL be combinational from valid_i, mode_i, sel_i, ptr, valid_o, and ready_i; there is no path from ready_i to data_o other than through the register.

Reset
REQ-026 While rstn_i is low at a clock edge: valid_o=0, data_o=0, chan_o=0, ptr=Channels-1, so the first round-robin grant searches from channel 0.
REQ-027 While rstn_i is low, all ready_o SHALL be 0; a word held mid-operation is discarded, not delivered.

Structure
REQ-028 A shared package mux_pkg SHALL hold the mode enum (MODE_FIXED=0, MODE_RR=1) and the index-width helper constant.
REQ-029 The round-robin search SHALL be a sub-module rr_arbiter, with inputs req and ptr and outputs grant one-hot, gnt_idx, and any_gnt, parametrised by Channels.

Verification (Length=8, Channels=4)
REQ-030 Reset: hold rstn_i=0 for 2 cycles with all valid_i=1 -> valid_o=0, data_o=0, chan_o=0, ready_o=4'b0000.
REQ-031 Fixed mode: mode_i=0, sel_i=2, valid_i=4'b1111, data ch2=8'hA5, ready_i=1 -> one cycle later data_o=8'hA5, chan_o=2, ready_o=4'b0100 every cycle.
REQ-032 Round-robin: mode_i=1, valid_i=4'b1011, ready_i=1 from reset -> chan_o sequence 0,1,3,0,1,3; no channel is starved.
REQ-033 Backpressure: valid_o=1, data_o=8'h3C, ready_i=0 for 5 cycles -> data_o stays 8'h3C, ready_o=0; on release, next word loads with no bubble.
REQ-034 Empty: valid_i=0 while ready_i=1 -> valid_o drops to 0 one cycle after the last transfer, and data_o holds its last value.
REQ-035 Mid-operation reset: rstn_i=0 while valid_o=1 and ready_i=0 -> next cycle valid_o=0, and after release the round-robin grant restarts at channel 0.
